// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the core requesters (IF, LSU), the arbiter and the RAM.
// The slave modport is the arbiter's view. The master modport is the
// surrounding environment, which drives the requests and the RAM read data.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  // Instruction-fetch requester
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  // Load/store requester
  logic              ls_req;
  logic              ls_we;
  logic [BE_W-1:0]   ls_be;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [DATA_W-1:0] ls_rdata;

  // Single-port synchronous RAM
  logic              mem_en;
  logic [BE_W-1:0]   mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  ls_req, ls_we, ls_be, ls_addr, ls_wdata,
    output ls_gnt, ls_rvalid, ls_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output ls_req, ls_we, ls_be, ls_addr, ls_wdata,
    input  ls_gnt, ls_rvalid, ls_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and the
// load/store unit. The LSU wins ties, but only for MAX_CONSEC grants in a row
// while fetch is waiting, so fetch always makes progress. The RAM answers one
// cycle after the access, and the owner register steers that answer back to
// whichever requester issued it.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_CONSEC = 4
) (
  input logic                clk_100,
  input logic                reset,
  mem_port_arbiter_if.slave  bus
);
  localparam int BE_W = DATA_W / 8;
  // MAX_CONSEC is limited to 1..15, so a 4-bit counter always holds it
  localparam logic [3:0] MAX_CNT = 4'(MAX_CONSEC);

  typedef enum logic {
    OWNER_IF = 1'b0,
    OWNER_LS = 1'b1
  } owner_e;

  // Registered state
  logic [3:0] cnt_q, cnt_d;
  logic       inflight_q, inflight_d;
  owner_e     owner_q, owner_d;

  // Combinational issue-side signals
  logic              if_gnt;
  logic              ls_gnt;
  logic              mem_en;
  logic [BE_W-1:0]   mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  // Completion-side signals
  logic              if_rvalid;
  logic              ls_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic [DATA_W-1:0] ls_rdata;

  // Pick this cycle's winner: the LSU unless fetch has been starved for MAX_CONSEC grants
  always_comb begin
    if_gnt = 1'b0;
    ls_gnt = 1'b0;
    if (!reset) begin
      if (bus.ls_req && (!bus.if_req || (cnt_q < MAX_CNT))) begin
        ls_gnt = 1'b1;
      end else if (bus.if_req) begin
        if_gnt = 1'b1;
      end
    end
  end

  // Drive the RAM from the granted requester; everything idles at zero otherwise
  always_comb begin
    mem_en    = if_gnt | ls_gnt;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (ls_gnt) begin
      mem_addr  = bus.ls_addr;
      mem_wdata = bus.ls_wdata;
      if (bus.ls_we) begin
        mem_we = bus.ls_be;
      end
    end else if (if_gnt) begin
      mem_addr = bus.if_addr;
    end
  end

  // Next state: count LSU wins while fetch waits, and remember who owns the in-flight access
  always_comb begin
    cnt_d = 4'd0;
    if (ls_gnt && bus.if_req) begin
      if (cnt_q >= MAX_CNT) begin
        cnt_d = MAX_CNT;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
    inflight_d = mem_en;
    owner_d    = ls_gnt ? OWNER_LS : OWNER_IF;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_100) begin
    if (reset) begin
      cnt_q      <= 4'd0;
      inflight_q <= 1'b0;
      owner_q    <= OWNER_IF;
    end else begin
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      owner_q    <= owner_d;
    end
  end

  // Route the RAM's answer to its owner; an access caught by reset is dropped
  always_comb begin
    if_rvalid = 1'b0;
    ls_rvalid = 1'b0;
    if_rdata  = '0;
    ls_rdata  = '0;
    if (inflight_q && !reset) begin
      if (owner_q == OWNER_LS) begin
        ls_rvalid = 1'b1;
        ls_rdata  = bus.mem_rdata;
      end else begin
        if_rvalid = 1'b1;
        if_rdata  = bus.mem_rdata;
      end
    end
  end

  assign bus.if_gnt    = if_gnt;
  assign bus.ls_gnt    = ls_gnt;
  assign bus.if_rvalid = if_rvalid;
  assign bus.ls_rvalid = ls_rvalid;
  assign bus.if_rdata  = if_rdata;
  assign bus.ls_rdata  = ls_rdata;
  assign bus.mem_en    = mem_en;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter. It models the RAM, drives request patterns
// cycle by cycle and checks the grants and RAM-side signals in the same cycle.
// Each expected completion is queued when its grant is expected. The queued
// entry holds the due cycle, the requester and the data, which comes from a
// reference copy of the memory. A monitor pops the entry and compares it
// against the rvalid and rdata outputs.
module tb_mem_port_arbiter;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int MAX_CONSEC = 4;

  typedef struct {
    int          due;
    bit          is_ls;
    bit          chk_data;
    logic [31:0] data;
  } sb_t;

  logic        clk_100 = 1'b0;
  logic        reset;
  logic [31:0] ram [0:255];
  logic [31:0] ref_mem [0:255];
  logic [31:0] ram_rdata;
  sb_t         sb_q[$];
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_CONSEC(MAX_CONSEC)
  ) dut (
    .clk_100(clk_100),
    .reset(reset),
    .bus(bus)
  );

  assign bus.mem_rdata = ram_rdata;

  // Free-running clock
  always #5 clk_100 = ~clk_100;

  // RAM model: one-cycle read latency, read-first on writes, garbage when idle
  always @(posedge clk_100) begin
    cyc <= cyc + 1;
    if (bus.mem_en) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.mem_we[b]) ram[bus.mem_addr[9:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end
      ram_rdata <= ram[bus.mem_addr[9:2]];
    end else begin
      ram_rdata <= 32'hDEAD_BEEF;
    end
  end

  // Single comparison point for the whole bench
  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Completion monitor: pops the scoreboard entry due this cycle, else expects silence
  always @(negedge clk_100) begin
    bit exp_if;
    bit exp_ls;
    exp_if = 1'b0;
    exp_ls = 1'b0;
    if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
      exp_if = !sb_q[0].is_ls;
      exp_ls = sb_q[0].is_ls;
    end
    check_output("if_rvalid", {63'd0, bus.if_rvalid}, {63'd0, exp_if});
    check_output("ls_rvalid", {63'd0, bus.ls_rvalid}, {63'd0, exp_ls});
    if (exp_if) check_output("if_rdata", {32'd0, bus.if_rdata}, {32'd0, sb_q[0].data});
    else        check_output("if_rdata_idle", {32'd0, bus.if_rdata}, 64'd0);
    if (exp_ls) begin
      if (sb_q[0].chk_data) check_output("ls_rdata", {32'd0, bus.ls_rdata}, {32'd0, sb_q[0].data});
    end else begin
      check_output("ls_rdata_idle", {32'd0, bus.ls_rdata}, 64'd0);
    end
    if (exp_if || exp_ls) void'(sb_q.pop_front());
  end

  // Drive one cycle of inputs, queue expected completions, check the issue side
  task automatic apply_stimulus(
    input string       tag,
    input logic        rst,
    input logic        ifr,
    input logic [31:0] ifa,
    input logic        lsr,
    input logic        lwe,
    input logic [3:0]  lbe,
    input logic [31:0] lsa,
    input logic [31:0] lwd,
    input logic        exp_ifg,
    input logic        exp_lsg,
    input logic        track
  );
    sb_t         e;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_we;
    reset        = rst;
    bus.if_req   = ifr;
    bus.if_addr  = ifa;
    bus.ls_req   = lsr;
    bus.ls_we    = lwe;
    bus.ls_be    = lbe;
    bus.ls_addr  = lsa;
    bus.ls_wdata = lwd;
    if (track && !rst) begin
      if (exp_lsg) begin
        e.due      = cyc + 1;
        e.is_ls    = 1'b1;
        e.chk_data = !lwe;
        e.data     = ref_mem[lsa[9:2]];
        if (lwe) begin
          for (int b = 0; b < 4; b++) begin
            if (lbe[b]) ref_mem[lsa[9:2]][8*b +: 8] = lwd[8*b +: 8];
          end
        end
        sb_q.push_back(e);
      end
      if (exp_ifg) begin
        e.due      = cyc + 1;
        e.is_ls    = 1'b0;
        e.chk_data = 1'b1;
        e.data     = ref_mem[ifa[9:2]];
        sb_q.push_back(e);
      end
    end
    exp_addr  = rst ? 32'd0 : (exp_lsg ? lsa : ifa);
    exp_wdata = (exp_lsg && !rst) ? lwd : 32'd0;
    exp_we    = (exp_lsg && lwe && !rst) ? lbe : 4'd0;
    @(negedge clk_100);
    check_output({tag, ".if_gnt"}, {63'd0, bus.if_gnt}, {63'd0, exp_ifg});
    check_output({tag, ".ls_gnt"}, {63'd0, bus.ls_gnt}, {63'd0, exp_lsg});
    check_output({tag, ".mem_en"}, {63'd0, bus.mem_en}, {63'd0, exp_ifg | exp_lsg});
    check_output({tag, ".mem_we"}, {60'd0, bus.mem_we}, {60'd0, exp_we});
    if (rst || exp_ifg || exp_lsg) begin
      check_output({tag, ".mem_addr"}, {32'd0, bus.mem_addr}, {32'd0, exp_addr});
      check_output({tag, ".mem_wdata"}, {32'd0, bus.mem_wdata}, {32'd0, exp_wdata});
    end
    @(posedge clk_100);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      apply_stimulus("idle", 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    end
  endtask

  // Main sequence
  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]     = 32'hA500_0000 | i;
      ref_mem[i] = 32'hA500_0000 | i;
    end
    ram[0]  = 32'h11;        ref_mem[0]  = 32'h11;
    ram[1]  = 32'h22;        ref_mem[1]  = 32'h22;
    ram[2]  = 32'h33;        ref_mem[2]  = 32'h33;
    ram[16] = 32'h1234_5678; ref_mem[16] = 32'h1234_5678;
    ram_rdata    = 32'd0;
    reset        = 1'b1;
    bus.if_req   = 1'b0;
    bus.if_addr  = 32'd0;
    bus.ls_req   = 1'b0;
    bus.ls_we    = 1'b0;
    bus.ls_be    = 4'd0;
    bus.ls_addr  = 32'd0;
    bus.ls_wdata = 32'd0;
    @(posedge clk_100);
    #1;

    // Reset forces grants and RAM outputs low even with both requests high
    for (int i = 0; i < 2; i++) begin
      apply_stimulus("rst", 1'b1, 1'b1, 32'h100, 1'b1, 1'b1, 4'hF, 32'h200, 32'h55, 1'b0, 1'b0, 1'b1);
    end

    // Fetch alone, back-to-back
    apply_stimulus("t1a", 1'b0, 1'b1, 32'h00, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
    apply_stimulus("t1b", 1'b0, 1'b1, 32'h04, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
    apply_stimulus("t1c", 1'b0, 1'b1, 32'h08, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
    idle(2);

    // Simultaneous requests: LSU first, fetch the next cycle
    apply_stimulus("t2a", 1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 4'd0, 32'h200, 32'd0, 1'b0, 1'b1, 1'b1);
    apply_stimulus("t2b", 1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 4'd0, 32'h200, 32'd0, 1'b1, 1'b0, 1'b1);
    idle(1);

    // Both held: fetch gets one slot after every MAX_CONSEC LSU grants
    for (int i = 0; i < 12; i++) begin
      apply_stimulus("t3", 1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 4'd0, 32'h200, 32'd0,
                     (i == 4 || i == 9), !(i == 4 || i == 9), 1'b1);
    end
    idle(1);

    // Partial write, read back, then a zero-byte-enable write that changes nothing
    apply_stimulus("t4w", 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 4'b0011, 32'h40, 32'hAABB_CCDD, 1'b0, 1'b1, 1'b1);
    apply_stimulus("t4r", 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 4'b0000, 32'h40, 32'd0, 1'b0, 1'b1, 1'b1);
    apply_stimulus("t4z", 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 4'b0000, 32'h44, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1);
    apply_stimulus("t4q", 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 4'b0000, 32'h44, 32'd0, 1'b0, 1'b1, 1'b1);
    // Misaligned fetch address passes through untouched
    apply_stimulus("mis", 1'b0, 1'b1, 32'h105, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
    idle(1);

    // Fetch granted, then reset: that access never completes
    apply_stimulus("t5g", 1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus("t5r", 1'b1, 1'b1, 32'h10, 1'b1, 1'b0, 4'd0, 32'h200, 32'd0, 1'b0, 1'b0, 1'b1);
    end
    for (int i = 0; i < 5; i++) begin
      apply_stimulus("t5a", 1'b0, 1'b1, 32'h10, 1'b1, 1'b0, 4'd0, 32'h200, 32'd0, (i == 4), (i != 4), 1'b1);
    end
    idle(1);

    // LSU alone, then fetch joins and waits for the counter to saturate
    for (int i = 0; i < 3; i++) begin
      apply_stimulus("t6s", 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'd0, 32'h300 + 4 * i, 32'd0, 1'b0, 1'b1, 1'b1);
    end
    for (int i = 0; i < 5; i++) begin
      apply_stimulus("t6b", 1'b0, 1'b1, 32'h20, 1'b1, 1'b0, 4'd0, 32'h300 + 4 * (i + 3), 32'd0,
                     (i == 4), (i != 4), 1'b1);
    end
    idle(3);

    check_output("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the processor's single-port synchronous instruction/data RAM between two requesters: the instruction-fetch unit (IF) and the load/store unit (LSU).
- Sits between the core and the RAM inside the top-level.
- Grants at most one access per cycle. LSU has priority, with a starvation guard so fetch always makes progress.
- Routes the one-cycle-latency read data back to the requester that issued the access.

Parameters:
- ADDR_W, 32, byte-address width of both requesters and the RAM port
- DATA_W, 32, data width (fixed at 32; the byte-enable width is DATA_W/8)
- MAX_CONSEC, 4, maximum consecutive LSU grants while IF is waiting; range 1..15

Ports:
- clk_100  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- if_req  in  1  IF requests a read; address held stable until granted
- if_addr  in  ADDR_W  IF byte address (word-aligned)
- if_gnt  out  1  IF access issued this cycle (combinational)
- if_rvalid  out  1  IF read data valid this cycle
- if_rdata  out  DATA_W  IF read data
- ls_req  in  1  LSU requests an access; held with all fields stable until granted
- ls_we  in  1  1 = write, 0 = read
- ls_be  in  DATA_W/8  byte enables for writes
- ls_addr  in  ADDR_W  LSU byte address (word-aligned)
- ls_wdata  in  DATA_W  LSU write data
- ls_gnt  out  1  LSU access issued this cycle (combinational)
- ls_rvalid  out  1  LSU completion: read data valid, or write acknowledged
- ls_rdata  out  DATA_W  LSU read data
- mem_en  out  1  RAM enable
- mem_we  out  DATA_W/8  RAM byte write enables
- mem_addr  out  ADDR_W  RAM byte address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid the cycle after mem_en

Behaviour:
- Reset (reset high at a clock edge) clears:
  - the owner register, the inflight flag and the starvation counter.
  - if_rvalid and ls_rvalid go 0 from the next cycle.
- While reset is high, if_gnt, ls_gnt, mem_en and mem_we are forced to 0.
- Data outputs while reset is high:
  - mem_addr and mem_wdata are 0.
  - if_rdata and ls_rdata are 0 whenever their rvalid is 0.
- Arbitration is combinational in cycle N and gated by the registered starvation counter `cnt`:
  - Only one requester active: it is granted.
  - Both requesting, cnt < MAX_CONSEC: LSU is granted.
  - Both requesting, cnt == MAX_CONSEC: IF is granted.
- Starvation counter update at the edge:
  - LSU granted while if_req=1: cnt increments, saturating at MAX_CONSEC.
  - IF granted, or if_req=0: cnt clears to 0.
- Issue in cycle N:
  - mem_en = if_gnt | ls_gnt.
  - mem_addr = the granted requester's address.
  - mem_we = ls_be if ls_gnt & ls_we, else 0.
  - mem_wdata = ls_wdata when LSU is granted, else 0.
- Completion:
  - At the edge ending cycle N, the owner register records {inflight=1, who=IF/LSU}; otherwise inflight=0.
  - In cycle N+1 exactly one of if_rvalid/ls_rvalid is asserted, according to who.
  - The matching rdata = mem_rdata (combinational pass-through). The other rdata output is 0.
  - An LSU write also produces ls_rvalid in N+1; ls_rdata is don't-care (drive mem_rdata).
- Throughput and latency:
  - A new grant may be issued in cycle N+1 while the previous completion is delivered, giving a sustained 1 access per cycle.
  - Read latency is grant -> rvalid = exactly 1 cycle.
- Requester rules:
  - A requester not granted keeps req and fields stable; no timeout.
  - Dropping req before grant is legal and produces no access.
- Reset mid-operation:
  - An access granted in the cycle before reset produces no rvalid.
  - cnt returns to 0.
- Invalid requests:
  - Misaligned addresses (addr[1:0] != 0) are passed through unmodified; the RAM ignores bits [1:0].
  - ls_be = 0 on a write performs an enable-only no-op but still acknowledges.

Test Plan:
1. Only IF requests addr 0x00, 0x04, 0x08 on consecutive cycles, RAM holding 0x11, 0x22, 0x33 -> if_gnt high 3 cycles; if_rvalid high in cycles 2-4 with if_rdata 0x11, 0x22, 0x33; ls_rvalid stays 0.
2. IF (0x100) and LSU read (0x200) both request in the same cycle -> ls_gnt first, mem_addr=0x200; next cycle if_gnt with mem_addr=0x100; ls_rvalid then if_rvalid on consecutive cycles.
3. MAX_CONSEC=4, if_req and ls_req held high for 12 cycles -> grant sequence LS,LS,LS,LS,IF,LS,LS,LS,LS,IF,LS,LS.
4. LSU write to 0x40 with ls_be=4'b0011, ls_wdata=0xAABBCCDD over old 0x12345678 -> mem_we=4'b0011; ls_rvalid the next cycle; a read back of 0x40 returns 0x1234CCDD.
5. IF granted at 0x10, reset asserted in the next cycle for 3 cycles while both req stay high -> no rvalid, no gnt and mem_en=0 during reset. First cycle after reset: ls_gnt, with cnt starting at 0.
6. LSU requests alone, then if_req rises after 3 LSU grants -> IF waits until cnt reaches MAX_CONSEC, i.e. IF is granted on the 5th cycle after it raised req.
